// File: rtl/pad_input_filter.sv
// Per-pad input conditioning: 2-flop synchronizer, optional debounce filter,
// clean level output and single-cycle rise/fall event pulses.
module pad_input_filter #(
  parameter int N_IO  = 48,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IO-1:0]  io_in_i,
  input  logic [N_IO-1:0]  filt_en_i,
  input  logic [CNT_W-1:0] debounce_thr_i,
  output logic [N_IO-1:0]  io_filt_o,
  output logic [N_IO-1:0]  rise_o,
  output logic [N_IO-1:0]  fall_o,
  output logic             event_o
);

  logic [N_IO-1:0]  s1_q;
  logic [N_IO-1:0]  s2_q;
  logic [N_IO-1:0]  stable_q;
  logic [N_IO-1:0]  stable_d;
  logic [N_IO-1:0]  rise_q;
  logic [N_IO-1:0]  fall_q;
  logic [CNT_W-1:0] cnt_q [N_IO];
  logic [CNT_W-1:0] cnt_d [N_IO];
  logic             thr_zero;

  assign thr_zero = (debounce_thr_i == '0);

  // Compare is done one bit wider so cnt+1 can never wrap before the >= test.
  always_comb begin
    stable_d = stable_q;
    for (int n = 0; n < N_IO; n++) begin
      cnt_d[n] = '0;
      if (!filt_en_i[n] || thr_zero) begin
        stable_d[n] = s2_q[n];
      end else if (s2_q[n] != stable_q[n]) begin
        if (({1'b0, cnt_q[n]} + (CNT_W+1)'(1)) >= {1'b0, debounce_thr_i}) begin
          stable_d[n] = s2_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int n = 0; n < N_IO; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      s1_q     <= io_in_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      // Pulses are registered alongside the level so they align with io_filt_o.
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
      for (int n = 0; n < N_IO; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign io_filt_o = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign event_o   = |(rise_q | fall_q);

endmodule

// File: tb/tb_pad_input_filter.sv
// Bench for pad_input_filter: directed latency/glitch/reset steps followed by
// randomized traffic, all checked against a run-length reference model.
module tb_pad_input_filter;

  localparam int N_IO  = 48;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [N_IO-1:0]  io_in;
  logic [N_IO-1:0]  filt_en;
  logic [CNT_W-1:0] thr;
  logic [N_IO-1:0]  io_filt;
  logic [N_IO-1:0]  rise;
  logic [N_IO-1:0]  fall;
  logic             ev;

  int total;
  int bad;

  // reference model state
  logic [N_IO-1:0] m_stab;
  logic [N_IO-1:0] m_rise;
  logic [N_IO-1:0] m_fall;
  int              m_run [N_IO];
  logic [N_IO-1:0] hist [$];

  pad_input_filter #(.N_IO(N_IO), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .io_in_i        (io_in),
    .filt_en_i      (filt_en),
    .debounce_thr_i (thr),
    .io_filt_o      (io_filt),
    .rise_o         (rise),
    .fall_o         (fall),
    .event_o        (ev)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_filt"}, 64'(io_filt), 64'(m_stab));
    check({tag, "_rise"}, 64'(rise), 64'(m_rise));
    check({tag, "_fall"}, 64'(fall), 64'(m_fall));
    check({tag, "_event"}, 64'(ev), 64'(|(m_rise | m_fall)));
  endtask

  task automatic model_reset();
    m_stab = '0;
    m_rise = '0;
    m_fall = '0;
    for (int n = 0; n < N_IO; n++) m_run[n] = 0;
    hist.delete();
  endtask

  // One clock edge: the model sees the pad value applied two edges earlier and
  // counts consecutive mismatching edges; a run of thr flips the level.
  task automatic tick();
    logic [N_IO-1:0] v;
    logic [N_IO-1:0] nxt;
    @(posedge clk);
    v = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    hist.push_back(io_in);
    if (hist.size() > 3) void'(hist.pop_front());
    nxt = m_stab;
    for (int n = 0; n < N_IO; n++) begin
      if (!filt_en[n] || int'(thr) == 0) begin
        nxt[n] = v[n];
        m_run[n] = 0;
      end else if (v[n] == m_stab[n]) begin
        m_run[n] = 0;
      end else if (m_run[n] + 1 >= int'(thr)) begin
        nxt[n] = v[n];
        m_run[n] = 0;
      end else begin
        m_run[n] = m_run[n] + 1;
      end
    end
    m_rise = nxt & ~m_stab;
    m_fall = ~nxt & m_stab;
    m_stab = nxt;
    @(negedge clk);
    check_all("step");
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // counts edges until the requested pulse appears on one pad, bounded by limit
  task automatic wait_edge(input int pad, input bit want_rise, input int limit, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!(want_rise ? rise[pad] : fall[pad]) && edges < limit);
  endtask

  int e;
  int r0, r17, r47;
  int thr_tab [6] = '{0, 1, 2, 3, 5, 7};

  initial begin
    total = 0;
    bad   = 0;
    rst     = 1'b1;
    io_in   = '0;
    filt_en = '0;
    thr     = '0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // bypass latency on pad 5
    io_in[5] = 1'b1;
    wait_edge(5, 1'b1, 10, e);
    check("bypass_lat", 64'(e), 64'd3);
    check("bypass_lvl", 64'(io_filt[5]), 64'd1);
    check("bypass_ev", 64'(ev), 64'd1);
    tick();
    check("bypass_single", 64'(rise[5]), 64'd0);

    // filter pass thr=4
    filt_en[0] = 1'b1;
    thr = 8'd4;
    io_in[0] = 1'b1;
    wait_edge(0, 1'b1, 20, e);
    check("filt_rise_lat", 64'(e), 64'd6);
    io_in[0] = 1'b0;
    wait_edge(0, 1'b0, 20, e);
    check("filt_fall_lat", 64'(e), 64'd6);
    ticks(2);

    // glitch rejection
    io_in[0] = 1'b1; ticks(3);
    io_in[0] = 1'b0; ticks(8);
    check("glitch3", 64'(io_filt[0]), 64'd0);
    io_in[0] = 1'b1; ticks(3);
    io_in[0] = 1'b0; ticks(1);
    io_in[0] = 1'b1; ticks(3);
    io_in[0] = 1'b0; ticks(8);
    check("glitch313", 64'(io_filt[0]), 64'd0);

    // thr=1
    thr = 8'd1;
    io_in[0] = 1'b1;
    wait_edge(0, 1'b1, 20, e);
    check("thr1_lat", 64'(e), 64'd3);

    // thr=0 with filter enabled acts as bypass
    thr = 8'd0;
    filt_en[1] = 1'b1;
    io_in[1] = 1'b1;
    wait_edge(1, 1'b1, 20, e);
    check("thr0_lat", 64'(e), 64'd3);

    // thr=255, no wrap
    thr = 8'd255;
    filt_en[2] = 1'b1;
    io_in[2] = 1'b1;
    wait_edge(2, 1'b1, 300, e);
    check("thr255_lat", 64'(e), 64'd257);
    check("thr255_lvl", 64'(io_filt[2]), 64'd1);

    // concurrency: pad 17 filtered thr=2, pads 0/47 bypassed
    filt_en = '0;
    filt_en[17] = 1'b1;
    thr = 8'd2;
    io_in[17] = 1'b0; io_in[47] = 1'b0; io_in[0] = 1'b0;
    ticks(5);
    io_in[0] = 1'b1; io_in[17] = 1'b1; io_in[47] = 1'b1;
    r0 = 0; r17 = 0; r47 = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (rise[0]  && r0  == 0) r0  = i;
      if (rise[17] && r17 == 0) r17 = i;
      if (rise[47] && r47 == 0) r47 = i;
    end
    check("conc_p0", 64'(r0), 64'd3);
    check("conc_p17", 64'(r17), 64'd4);
    check("conc_p47", 64'(r47), 64'd3);

    // async reset mid-count
    filt_en[3] = 1'b1;
    thr = 8'd8;
    io_in[3] = 1'b1;
    ticks(5);
    #1 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #1 rst = 1'b0;
    wait_edge(3, 1'b1, 20, e);
    check("rst_release_lat", 64'(e), 64'd10);

    // randomized traffic with mode and threshold changes
    for (int seg = 0; seg < 6; seg++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      filt_en = r[N_IO-1:0];
      thr = CNT_W'(thr_tab[$urandom_range(0, 5)]);
      for (int c = 0; c < 150; c++) begin
        for (int n = 0; n < N_IO; n++) begin
          if ($urandom_range(0, 5) == 0) io_in[n] = ~io_in[n];
        end
        if ($urandom_range(0, 19) == 0) thr = CNT_W'(thr_tab[$urandom_range(0, 5)]);
        if ($urandom_range(0, 29) == 0) begin
          int p;
          p = int'($urandom_range(0, N_IO-1));
          filt_en[p] = ~filt_en[p];
        end
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
